wb_write_queue: RTL

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_write_queue.sv
// wb_write_queue: writeback result queue feeding a single register-file
// write port. Results targeting r1..r31 are queued in FIFO order and
// drained one per cycle into registered we/wa/wd unless the write port
// stalls. Results with in_we=0 or in_wa=0 are consumed and dropped.
//
// Optional feature: define WB_WRITE_QUEUE_FWD_EN to build the decode-stage
// bypass lookup (fwd1_*/fwd2_*). Without it those outputs are tied to 0.
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [4:0]  in_wa,
  input  logic [31:0] in_wd,
  input  logic        rf_stall,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data,
  output logic        pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            accept;
  logic            push;
  logic            pop;
  logic            not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = (count != FULL_CNT);
  assign accept    = in_valid && in_ready;
  assign push      = accept && in_we && (in_wa != 5'd0);
  assign pop       = !rf_stall && not_empty;
  assign pending   = not_empty || we;

  // Queue storage: write the tail entry on a push.
  // NOTE: storage has no reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{wa: in_wa, wd: in_wd};
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end

  // Register-file write register: load the head on pop, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we <= 1'b0;
      wa <= 5'd0;
      wd <= 32'd0;
    end else if (!rf_stall) begin
      if (not_empty) begin
        we <= 1'b1;
        wa <= mem[rd_ptr].wa;
        wd <= mem[rd_ptr].wd;
      end else begin
        we <= 1'b0;
      end
    end
  end

`ifdef WB_WRITE_QUEUE_FWD_EN
  logic [AW-1:0] idx;

  // Bypass lookup: output register first, then queue oldest to youngest,
  // so later matches override earlier ones and the youngest wins.
  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = 32'd0;
    fwd2_data = 32'd0;
    idx       = rd_ptr;
    if (we && (wa == ra1) && (ra1 != 5'd0)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = wd;
    end
    if (we && (wa == ra2) && (ra2 != 5'd0)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = wd;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((AW+1)'(i) < count) begin
        if ((mem[idx].wa == ra1) && (ra1 != 5'd0)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem[idx].wd;
        end
        if ((mem[idx].wa == ra2) && (ra2 != 5'd0)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem[idx].wd;
        end
      end
    end
  end
`else
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = 32'd0;
  assign fwd2_data = 32'd0;
`endif

endmodule
